// File: rtl/inst_loader.sv
// Program loader: assembles big-endian words from a byte stream (length word, then N words),
// writes them to instruction memory, then releases the core with cpu_start / load_done.
module inst_loader #(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  loading,
  output logic                  load_done,
  output logic                  cpu_start,
  output logic                  load_err
);

  // S_FIN is the cycle carrying the final write pulse, so cpu_start lands one cycle later.
  typedef enum logic [1:0] {S_LEN, S_DATA, S_FIN, S_DONE} state_t;

  localparam logic [32:0] DEPTH = 33'd1 << ADDR_WIDTH;

  state_t                r_state;
  state_t                w_state_next;
  logic [1:0]            r_byte_cnt;
  logic [23:0]           r_shift;
  logic [31:0]           r_word_idx;
  logic [31:0]           r_len;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic                  r_start;
  logic                  r_err;

  logic                  w_xfer;
  logic                  w_complete;
  logic [31:0]           w_word;
  logic                  w_in_range;
  logic                  w_last;
  logic                  w_len_over;

  assign w_xfer     = rx_valid && rx_ready;
  assign w_complete = w_xfer && (r_byte_cnt == 2'd3);
  assign w_word     = {r_shift, rx_data};
  assign w_in_range = ({1'b0, r_word_idx} < DEPTH);
  assign w_last     = ((r_word_idx + 32'd1) == r_len);
  assign w_len_over = ({1'b0, w_word} > DEPTH);

  always_comb begin
    w_state_next = r_state;
    rx_ready     = 1'b0;
    loading      = 1'b0;
    load_done    = 1'b0;
    case (r_state)
      S_LEN: begin
        rx_ready = 1'b1;
        loading  = 1'b1;
        if (w_complete) begin
          w_state_next = (w_word == 32'd0) ? S_DONE : S_DATA;
        end
      end
      S_DATA: begin
        rx_ready = 1'b1;
        loading  = 1'b1;
        if (w_complete && w_last) begin
          w_state_next = S_FIN;
        end
      end
      S_FIN: begin
        w_state_next = S_DONE;
      end
      S_DONE: begin
        load_done = 1'b1;
      end
      default: w_state_next = S_LEN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_LEN;
      r_byte_cnt <= 2'd0;
      r_shift    <= 24'd0;
      r_word_idx <= 32'd0;
      r_len      <= 32'd0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= 32'd0;
      r_start    <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_we    <= 1'b0;
      r_start <= (r_state != S_DONE) && (w_state_next == S_DONE);
      if (w_xfer) begin
        r_shift    <= w_word[23:0];
        r_byte_cnt <= r_byte_cnt + 2'd1;
      end
      if (w_complete && (r_state == S_LEN)) begin
        r_len <= w_word;
        if (w_len_over) begin
          r_err <= 1'b1;
        end
      end
      // Words past the memory depth are still consumed and counted, just not written.
      if (w_complete && (r_state == S_DATA)) begin
        r_word_idx <= r_word_idx + 32'd1;
        if (w_in_range) begin
          r_we    <= 1'b1;
          r_addr  <= r_word_idx[ADDR_WIDTH-1:0];
          r_wdata <= w_word;
        end
      end
    end
  end

  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign cpu_start  = r_start;
  assign load_err   = r_err;

endmodule

// File: doc/inst_loader.md
Name: inst_loader

Overview:
- Loads a program into instruction memory before the core runs.
- Consumes the byte stream from the UART receiver and assembles it into big-endian 32-bit instruction words.
- Writes each word sequentially into the instruction memory write port, then releases the core via a start pulse and a level-held done flag.
- Sits between uart_rx and the instruction memory that feeds `inst` to the core top. It is the producer end of the core's instruction interface.

Parameters:
- ADDR_WIDTH, 14, word-address width of instruction memory; depth = 2^ADDR_WIDTH words.

Ports:
- clk  input  1  system clock, all logic rising-edge.
- rst  input  1  synchronous reset, active-high.
- rx_data  input  8  received byte.
- rx_valid  input  1  rx_data valid this cycle.
- rx_ready  output  1  loader accepts a byte; a transfer occurs on rx_valid && rx_ready.
- imem_we  output  1  instruction memory write enable, one-cycle pulse per word.
- imem_addr  output  ADDR_WIDTH  word address of the write.
- imem_wdata  output  32  instruction word.
- loading  output  1  high while in S_LEN or S_DATA.
- load_done  output  1  high in S_DONE, held until reset.
- cpu_start  output  1  single-cycle pulse on entry to S_DONE.
- load_err  output  1  sticky; set when the word count exceeds depth.

Behaviour:
- Reset: in the cycle after rst is sampled high:
  - state = S_LEN; byte_cnt = 0; word_idx = 0; len = 0.
  - rx_ready = 1; loading = 1.
  - imem_we = 0, imem_addr = 0, imem_wdata = 0.
  - load_done = 0, cpu_start = 0, load_err = 0.
- Reset mid-load aborts the transfer. The memory keeps any words already written. A partial word in the shift register is discarded.
- Frame format:
  - 4-byte big-endian word count N.
  - Then N words, each 4 bytes, MSB first.
- Byte assembly: on each transfer, shift = {shift[23:0], rx_data}; byte_cnt increments mod 4. The 4th byte (byte_cnt == 3) completes a word.
- S_LEN:
  - On word completion, len <= assembled value.
  - If the value is 0, go to S_DONE next cycle.
  - Otherwise go to S_DATA.
  - If the value > 2^ADDR_WIDTH, load_err <= 1 (sticky).
- S_DATA, on word completion:
  - If word_idx < 2^ADDR_WIDTH: next cycle imem_we = 1, imem_addr = word_idx[ADDR_WIDTH-1:0], imem_wdata = assembled word.
  - Otherwise no write; the bytes are still consumed.
  - word_idx increments, 32-bit wide, no wrap.
  - When word_idx + 1 == len, go to S_DONE.
- Write latency: imem_we is asserted exactly 1 cycle after the transfer of the 4th byte of a word, for 1 cycle. imem_addr and imem_wdata hold their last values when imem_we = 0.
- S_DONE:
  - rx_ready = 0, loading = 0, load_done = 1.
  - cpu_start = 1 in the first S_DONE cycle only.
  - Entry cycle: the cycle after the final write pulse, or the cycle after the length word when N = 0. The final imem_we and the cpu_start pulse are therefore never in the same cycle.
  - Stays in S_DONE until rst.
- Stalls: rx_ready = 1 in S_LEN and S_DATA, so no backpressure during load. Gaps in rx_valid of any length are permitted; state and partial bytes hold across gaps.
- Bytes with rx_valid high in S_DONE are not accepted (rx_ready = 0) and have no effect.
- rx_valid asserted together with rst: the byte is ignored; reset wins.

Test Plan:
- Basic load:
  - Stimulus: rst pulse, then bytes 00 00 00 02, 20 01 00 05, AC 22 00 00, back-to-back.
  - Required: write addr 0 = 0x20010005 one cycle after byte 8; write addr 1 = 0xAC220000 one cycle after byte 12; cpu_start one pulse the cycle after; load_done = 1; rx_ready = 0.
- Zero length:
  - Stimulus: bytes 00 00 00 00.
  - Required: no imem_we; cpu_start pulses the cycle after the 4th byte; load_err = 0.
- Gapped input:
  - Stimulus: same as basic, with rx_valid low for 0–5 random cycles between bytes.
  - Required: identical write contents; each write occurs 1 cycle after its 4th byte.
- Overflow (ADDR_WIDTH = 2):
  - Stimulus: N = 5, words 0x11111111 to 0x55555555.
  - Required: load_err = 1 after the length word; writes only to addr 0–3; word 5 consumed without a write; then done.
- Reset mid-load:
  - Stimulus: assert rst after 6 bytes of the basic frame, then send the full basic frame.
  - Required: no write from the partial frame; fresh writes to addr 0 and 1 with the correct data; single cpu_start.
- Post-done input:
  - Stimulus: after done, drive rx_valid = 1 with FF for 10 cycles.
  - Required: no imem_we; rx_ready stays 0; no further cpu_start.
